// File: rtl/ofb_ctrl.sv
// AES-128 OFB session controller: sequences the shared encrypt core to produce
// the keystream and XORs it onto a plaintext valid/ready stream.
//
// state   | meaning
// IDLE    | waiting for start; key/iv/num_blocks latched on start
// KS_REQ  | one-cycle aes_start with aes_in = feedback register
// KS_WAIT | waiting for aes_done; result becomes keystream and new feedback
// PT_WAIT | pt_ready high; plaintext XOR keystream registered on handshake
// OUT     | ct_valid high until ct_ready; block count advances on handshake
// FIN     | one-cycle done pulse, then back to IDLE
module ofb_ctrl #(
  parameter int NBLK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [127:0]      key,
  input  logic [127:0]      iv,
  input  logic [NBLK_W-1:0] num_blocks,
  input  logic [127:0]      pt_data,
  input  logic              pt_valid,
  output logic              pt_ready,
  output logic [127:0]      ct_data,
  output logic              ct_valid,
  input  logic              ct_ready,
  output logic              aes_start,
  output logic [127:0]      aes_key,
  output logic [127:0]      aes_in,
  input  logic [127:0]      aes_out,
  input  logic              aes_done,
  output logic              busy,
  output logic              done,
  output logic [NBLK_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KS_REQ  = 3'd1,
    KS_WAIT = 3'd2,
    PT_WAIT = 3'd3,
    OUT     = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [127:0]        r_key;
  logic [127:0]        r_fb;
  logic [127:0]        r_ks;
  logic [127:0]        r_ct;
  logic [NBLK_W-1:0]   r_nblk;
  logic [NBLK_W-1:0]   r_cnt;
  logic [NBLK_W-1:0]   w_cnt_inc;

  // num_blocks = 0 naturally means 2^NBLK_W: the incremented count wraps to 0
  assign w_cnt_inc = r_cnt + {{(NBLK_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_fb    <= '0;
      r_ks    <= '0;
      r_ct    <= '0;
      r_nblk  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_key  <= key;
            r_fb   <= iv;
            r_nblk <= num_blocks;
            r_cnt  <= '0;
          end
        end
        KS_WAIT: begin
          if (aes_done) begin
            r_ks <= aes_out;
            r_fb <= aes_out;
          end
        end
        PT_WAIT: begin
          if (pt_valid) r_ct <= pt_data ^ r_ks;
        end
        OUT: begin
          if (ct_ready) r_cnt <= w_cnt_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    aes_start   = 1'b0;
    pt_ready    = 1'b0;
    ct_valid    = 1'b0;
    done        = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE:    if (start) w_state_nxt = KS_REQ;
      KS_REQ: begin
        aes_start   = 1'b1;
        w_state_nxt = KS_WAIT;
      end
      KS_WAIT: if (aes_done) w_state_nxt = PT_WAIT;
      PT_WAIT: begin
        pt_ready = 1'b1;
        if (pt_valid) w_state_nxt = OUT;
      end
      OUT: begin
        ct_valid = 1'b1;
        if (ct_ready) w_state_nxt = (w_cnt_inc == r_nblk) ? FIN : KS_REQ;
      end
      FIN: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign aes_key = r_key;
  assign aes_in  = r_fb;
  assign ct_data = r_ct;
  assign blk_cnt = r_cnt;

endmodule

// File: tb/tb_ofb_ctrl.sv
// Scoreboard bench for ofb_ctrl: two instances (NBLK_W=16 and NBLK_W=2), each
// served by a 5-cycle behavioural AES stand-in; a monitor pops expected ciphertext.
module tb_ofb_ctrl;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IV2 = 128'h04C723C31896059A071280E2EB27B275;
  localparam logic [127:0] O1  = 128'h50fe67cc996d32b6da0937e99bafec60;
  localparam logic [127:0] O2  = 128'hd9a4dada0892239f6b8b3d7680e15674;
  localparam logic [127:0] O3  = 128'ha78819583f0308e7a6bf36b1386abf23;
  localparam logic [127:0] O4  = 128'hc6d3416d29165c6fcb8e51a227ba994e;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] P4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] C1  = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
  localparam logic [127:0] C2  = 128'h7789508d16918f03f53c52dac54ed825;
  localparam logic [127:0] C3  = 128'h9740051e9c5fecf64344f7a82260edcc;
  localparam logic [127:0] C4  = 128'h304c6528f659c77866a510d9c1d6ae5e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0, iv = '0, pt_data = '0;
  logic         pt_valid = 1'b0, ct_ready = 1'b1;
  logic [15:0]  nb16 = '0;
  logic [1:0]   nb2 = '0;

  logic         a_start, a_pt_ready, a_ct_valid, a_aes_start, a_busy, a_done;
  logic [127:0] a_ct_data, a_aes_key, a_aes_in;
  logic [15:0]  a_blk;
  logic [127:0] a_aes_out = '0;
  logic         a_aes_done = 1'b0;

  logic         b_start, b_pt_ready, b_ct_valid, b_aes_start, b_busy, b_done;
  logic [127:0] b_ct_data, b_aes_key, b_aes_in;
  logic [1:0]   b_blk;
  logic [127:0] b_aes_out = '0;
  logic         b_aes_done = 1'b0;

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  ofb_ctrl #(.NBLK_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .key(key), .iv(iv), .num_blocks(nb16),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(a_pt_ready),
    .ct_data(a_ct_data), .ct_valid(a_ct_valid), .ct_ready(ct_ready),
    .aes_start(a_aes_start), .aes_key(a_aes_key), .aes_in(a_aes_in),
    .aes_out(a_aes_out), .aes_done(a_aes_done),
    .busy(a_busy), .done(a_done), .blk_cnt(a_blk)
  );

  ofb_ctrl #(.NBLK_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .key(key), .iv(iv), .num_blocks(nb2),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(b_pt_ready),
    .ct_data(b_ct_data), .ct_valid(b_ct_valid), .ct_ready(ct_ready),
    .aes_start(b_aes_start), .aes_key(b_aes_key), .aes_in(b_aes_in),
    .aes_out(b_aes_out), .aes_done(b_aes_done),
    .busy(b_busy), .done(b_done), .blk_cnt(b_blk)
  );

  logic         cur_pt_ready, cur_ct_valid, cur_aes_start, cur_busy, cur_done;
  logic [127:0] cur_ct_data, cur_aes_key, cur_aes_in;
  logic [15:0]  cur_blk;
  assign cur_pt_ready  = sel ? b_pt_ready  : a_pt_ready;
  assign cur_ct_valid  = sel ? b_ct_valid  : a_ct_valid;
  assign cur_aes_start = sel ? b_aes_start : a_aes_start;
  assign cur_busy      = sel ? b_busy      : a_busy;
  assign cur_done      = sel ? b_done      : a_done;
  assign cur_ct_data   = sel ? b_ct_data   : a_ct_data;
  assign cur_aes_key   = sel ? b_aes_key   : a_aes_key;
  assign cur_aes_in    = sel ? b_aes_in    : a_aes_in;
  assign cur_blk       = sel ? {14'd0, b_blk} : a_blk;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] pt_list[$];
  logic [127:0] ct_list[$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // AES stand-in: exact SP800-38A OFB chain for the reference key, otherwise a fixed mix
  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] d);
    if (k == KEY && d == IV) return O1;
    if (k == KEY && d == O1) return O2;
    if (k == KEY && d == O2) return O3;
    if (k == KEY && d == O3) return O4;
    return {d[95:0], d[127:96]} ^ k ^ 128'h5a5a_1234_c3c3_8765_0f0f_abcd_9696_4321;
  endfunction

  // core models are deliberately not reset so a stale aes_done can follow a reset
  int a_cnt = 0, b_cnt = 0;
  logic [127:0] a_k = '0, a_d = '0, b_k = '0, b_d = '0;
  always @(posedge clk) begin
    a_aes_done <= 1'b0;
    if (a_aes_start) begin
      a_cnt <= 5; a_k <= a_aes_key; a_d <= a_aes_in;
    end else if (a_cnt > 0) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) begin
        a_aes_done <= 1'b1;
        a_aes_out  <= aes_model(a_k, a_d);
      end
    end
  end
  always @(posedge clk) begin
    b_aes_done <= 1'b0;
    if (b_aes_start) begin
      b_cnt <= 5; b_k <= b_aes_key; b_d <= b_aes_in;
    end else if (b_cnt > 0) begin
      b_cnt <= b_cnt - 1;
      if (b_cnt == 1) begin
        b_aes_done <= 1'b1;
        b_aes_out  <= aes_model(b_k, b_d);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cur_ct_valid && ct_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ct_unexpected: got %h expected no block", cur_ct_data);
        end else begin
          check("ct_data", cur_ct_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_session(input bit s, input logic [127:0] k, input logic [127:0] v,
                             input int nb, input int n, input int bp_blk, input bit poke,
                             input logic [15:0] exp_blk);
    logic [127:0] fb;
    bit seen;
    sel = s; key = k; iv = v; nb16 = nb[15:0]; nb2 = nb[1:0];
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fb = v;
    for (int i = 0; i < n; i++) begin
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin @(negedge clk); seen = cur_aes_start; end
      if (!seen) begin total++; bad++; $display("FAIL aes_start_timeout: got none expected block %0d", i); return; end
      check("aes_in", cur_aes_in, fb);
      check("aes_key", cur_aes_key, k);
      check("busy", 128'(cur_busy), 128'(1));
      fb = aes_model(k, fb);
      if (poke && i == 1) begin
        iv = ~v; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; iv = v;
      end
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin @(negedge clk); seen = cur_pt_ready; end
      if (!seen) begin total++; bad++; $display("FAIL pt_ready_timeout: got none expected block %0d", i); return; end
      pt_data = pt_list[i]; pt_valid = 1'b1;
      exp_q.push_back(ct_list[i]);
      if (i == bp_blk) ct_ready = 1'b0;
      @(posedge clk); #1 pt_valid = 1'b0;
      if (i == bp_blk) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("bp_ct_valid", 128'(cur_ct_valid), 128'(1));
          check("bp_ct_data", cur_ct_data, ct_list[i]);
          check("bp_no_aes_start", 128'(cur_aes_start), 128'(0));
          check("bp_blk_cnt", 128'(cur_blk), 128'(i));
        end
        @(posedge clk); #1 ct_ready = 1'b1;
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin @(negedge clk); seen = cur_done; end
    if (!seen) begin total++; bad++; $display("FAIL done_timeout: got none expected done pulse"); return; end
    check("blk_cnt_final", 128'(cur_blk), 128'(exp_blk));
    @(negedge clk);
    check("done_one_cycle", 128'(cur_done), 128'(0));
    check("idle_not_busy", 128'(cur_busy), 128'(0));
    check("blk_cnt_hold", 128'(cur_blk), 128'(exp_blk));
    check("blocks_all_out", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic build_lists(input logic [127:0] k, input logic [127:0] v, input int n,
                             input logic [127:0] seed);
    logic [127:0] fb, p;
    pt_list.delete(); ct_list.delete();
    fb = v;
    for (int i = 0; i < n; i++) begin
      p  = seed ^ 128'(i * 32'h1111_0101);
      fb = aes_model(k, fb);
      pt_list.push_back(p);
      ct_list.push_back(p ^ fb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #2;
    check("rst_ctl_a", 128'({a_aes_start, a_ct_valid, a_pt_ready, a_busy, a_done, a_blk}), 128'(0));
    check("rst_data_a", a_ct_data | a_aes_key | a_aes_in, 128'(0));
    check("rst_ctl_b", 128'({b_aes_start, b_ct_valid, b_pt_ready, b_busy, b_done, b_blk}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;

    // known-answer single block
    pt_list.delete(); ct_list.delete();
    pt_list.push_back(P1); ct_list.push_back(C1);
    run_session(1'b0, KEY, IV, 1, 1, -1, 1'b0, 16'd1);

    // four-block feedback chain with back-pressure on the second block
    pt_list.delete(); ct_list.delete();
    pt_list.push_back(P1); pt_list.push_back(P2); pt_list.push_back(P3); pt_list.push_back(P4);
    ct_list.push_back(C1); ct_list.push_back(C2); ct_list.push_back(C3); ct_list.push_back(C4);
    run_session(1'b0, KEY, IV, 4, 4, 1, 1'b0, 16'd4);

    // reset during KS_WAIT, then a stale aes_done from the core
    sel = 1'b0; key = KEY; iv = IV; nb16 = 16'd1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = a_aes_start; end
    if (!seen) begin total++; bad++; $display("FAIL rst_test_timeout: got none expected aes_start"); end
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("async_rst_ctl", 128'({a_aes_start, a_ct_valid, a_pt_ready, a_busy, a_done, a_blk}), 128'(0));
    check("async_rst_data", a_ct_data | a_aes_key | a_aes_in, 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("post_rst_ctl", 128'({a_aes_start, a_ct_valid, a_pt_ready, a_busy, a_done, a_blk}), 128'(0));
      check("post_rst_data", a_ct_data | a_aes_key | a_aes_in, 128'(0));
    end
    build_lists(KEY, IV2, 1, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff);
    run_session(1'b0, KEY, IV2, 1, 1, -1, 1'b0, 16'd1);

    // NBLK_W=2, num_blocks=0 -> four blocks, count wraps to 0; start while busy ignored
    build_lists(128'hfeed_face_0bad_f00d_1357_9bdf_2468_ace0, 128'h7777_0000_3333_1111_aaaa_5555_cccc_9999,
                4, 128'hdead_beef_cafe_babe_0123_4567_89ab_cdef);
    run_session(1'b1, 128'hfeed_face_0bad_f00d_1357_9bdf_2468_ace0,
                128'h7777_0000_3333_1111_aaaa_5555_cccc_9999, 0, 4, -1, 1'b1, 16'd0);

    repeat (10) @(negedge clk);
    check("no_stray_blocks", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
